// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scanner_if
// Brief   : Keypad matrix pins and accepted-key outputs of the scanner.
// Revision: 1.0
// ============================================================================
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row_n,
        output col_n,
        output key,
        output key_valid,
        output key_down
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key,
        input  key_valid,
        input  key_down
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scanner
// Brief   : 4x4 keypad column scanner with frame-level press/release debounce.
// Revision: 1.0
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master bus
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [DW-1:0] C_DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] C_DIV_ONE  = DW'(1);
    localparam logic [CW-1:0] C_DF       = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] C_ONE      = CW'(1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    localparam logic [1:0] HIT_NONE   = 2'd0;
    localparam logic [1:0] HIT_SINGLE = 2'd1;
    localparam logic [1:0] HIT_MULTI  = 2'd2;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
            4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
            4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
            4'hC: code = 4'd15;  4'hD: code = 4'd0;   4'hE: code = 4'd14;  default: code = 4'd13;
        endcase
        return code;
    endfunction

    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_sync_q, row_sync_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    acc_hits_q, acc_hits_d;
    logic [3:0]    acc_key_q, acc_key_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic [3:0]    w_pressed;
    logic [2:0]    w_col_cnt;
    logic [1:0]    w_col_class;
    logic [1:0]    w_row_idx;
    logic [1:0]    w_base_hits;
    logic [1:0]    w_total;
    logic [3:0]    w_frame_key;
    logic          w_sample;
    logic          w_frame_end;
    logic          w_accept;
    logic [3:0]    w_accept_key;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_rel_inc;

    // Classify the current column sample and fold it into the running frame result
    always_comb begin
        w_pressed   = ~row_sync_q;
        w_col_cnt   = 3'(w_pressed[0]) + 3'(w_pressed[1]) + 3'(w_pressed[2]) + 3'(w_pressed[3]);
        w_col_class = (w_col_cnt == 3'd0) ? HIT_NONE :
                      (w_col_cnt == 3'd1) ? HIT_SINGLE : HIT_MULTI;
        w_row_idx   = w_pressed[0] ? 2'd0 :
                      w_pressed[1] ? 2'd1 :
                      w_pressed[2] ? 2'd2 : 2'd3;
        w_base_hits = (col_q == 2'd0) ? HIT_NONE : acc_hits_q;
        if (w_base_hits == HIT_NONE) begin
            w_total = w_col_class;
        end else if (w_col_class == HIT_NONE) begin
            w_total = w_base_hits;
        end else begin
            w_total = HIT_MULTI;
        end
        w_frame_key = (w_col_class == HIT_SINGLE) ? key_code(w_row_idx, col_q) : acc_key_q;
        w_sample    = (div_q == C_DIV_LAST);
        w_frame_end = w_sample && (col_q == 2'd3);
        w_cnt_inc   = (cnt_q == C_DF) ? cnt_q : cnt_q + C_ONE;
        w_rel_inc   = (rel_q == C_DF) ? rel_q : rel_q + C_ONE;
    end

    always_comb begin
        row_meta_d   = bus.row_n;
        row_sync_d   = row_meta_q;
        div_d        = div_q + C_DIV_ONE;
        col_d        = col_q;
        acc_hits_d   = acc_hits_q;
        acc_key_d    = acc_key_q;
        state_d      = state_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        rel_d        = rel_q;
        key_d        = key_q;
        key_valid_d  = 1'b0;
        key_down_d   = key_down_q;
        w_accept     = 1'b0;
        w_accept_key = cand_q;

        if (w_sample) begin
            div_d      = '0;
            col_d      = col_q + 2'd1;
            acc_hits_d = w_total;
            acc_key_d  = w_frame_key;
        end

        if (w_frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_total == HIT_SINGLE) begin
                        cand_d = w_frame_key;
                        cnt_d  = C_ONE;
                        if (C_ONE >= C_DF) begin
                            w_accept     = 1'b1;
                            w_accept_key = w_frame_key;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_total == HIT_SINGLE) begin
                        if (w_frame_key == cand_q) begin
                            cnt_d = w_cnt_inc;
                            if (w_cnt_inc >= C_DF) begin
                                w_accept = 1'b1;
                            end
                        end else begin
                            cand_d = w_frame_key;
                            cnt_d  = C_ONE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    // Any activity while held, including a second key, only restarts the release count
                    if (w_total == HIT_NONE) begin
                        if (w_rel_inc >= C_DF) begin
                            key_down_d = 1'b0;
                            rel_d      = '0;
                            state_d    = ST_IDLE;
                        end else begin
                            rel_d = w_rel_inc;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (w_accept) begin
            key_d       = w_accept_key;
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            rel_d       = '0;
            cnt_d       = '0;
            state_d     = ST_HELD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            col_q       <= 2'd0;
            acc_hits_q  <= HIT_NONE;
            acc_key_q   <= 4'd0;
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            rel_q       <= '0;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            div_q       <= div_d;
            col_q       <= col_d;
            acc_hits_q  <= acc_hits_d;
            acc_key_q   <= acc_key_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    always_comb begin
        case (col_q)
            2'd0:    bus.col_n = 4'b1110;
            2'd1:    bus.col_n = 4'b1101;
            2'd2:    bus.col_n = 4'b1011;
            default: bus.col_n = 4'b0111;
        endcase
    end

    assign bus.key       = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_down  = key_down_q;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad, debounces it and emits one 4-bit key code plus a one-cycle strobe per press.
- Directly upstream of the calculator output decoder.
- Its key_valid and key, together with the 2-bit control state, form the decoder's 7-bit input {key_valid, state[1:0], key[3:0]}.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven. Must be >= 4.
- DEBOUNCE_FRAMES, 8: number of consecutive identical full scan frames required to accept a press, and also to accept a release. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_n  output  4  column drive, active-low, exactly one column low at any time
- key  output  4  code of last accepted key, held between strobes
- key_valid  output  1  one-cycle strobe, key is valid in that cycle
- key_down  output  1  high while an accepted key has not yet been released

Behaviour:
- Reset values (asynchronous on rst high):
  - col_n=4'b1110, key=0, key_valid=0, key_down=0.
  - FSM in IDLE; all counters 0.
  - Reset mid-debounce or mid-hold discards the press with no strobe.
- Synchronizer: row_n passes through a 2-flop synchronizer before any use.
- Scan:
  - Column c (0..3) is driven low for SCAN_DIV cycles.
  - Order is 0,1,2,3 and then wraps to 0.
  - Synchronized rows are sampled on the last cycle of each column slot.
  - One frame is 4*SCAN_DIV cycles; a frame ends at the column-3 sample.
- Key map (row r, col c):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *,0,#,D
- Codes: digits 0-9 map to 0-9, A=10, B=11, C=12, D=13, #=14, *=15.
- Frame result:
  - NONE: no row low in any column.
  - SINGLE(k): exactly one row/column intersection low in the whole frame.
  - MULTI: two or more intersections low.
- FSM is evaluated only at frame end:
  - IDLE:
    - SINGLE(k): cand=k, cnt=1. If DEBOUNCE_FRAMES==1, accept immediately (see Accept); else go to DEBOUNCE.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_FRAMES, accept.
    - SINGLE(j != cand): cand=j, cnt=1, stay in DEBOUNCE.
    - NONE or MULTI: go to IDLE, cnt=0.
  - Accept:
    - key<=cand and key_valid<=1 on the clock edge after the frame-end sample; key_valid returns to 0 on the next edge.
    - key_down<=1, rel=0, go to HELD.
  - HELD:
    - NONE: rel++. When rel reaches DEBOUNCE_FRAMES, key_down<=0 and go to IDLE.
    - SINGLE(any) or MULTI: rel=0, stay in HELD.
    - No auto-repeat: a second key pressed while the first is held is never reported.
- Counters saturate; they never wrap.
- key changes only in the cycle of a strobe.
- Latency: the strobe follows the frame end of the DEBOUNCE_FRAMES-th consecutive matching frame by exactly 1 cycle.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3, so one frame is 16 cycles.
1. Reset: assert rst mid-scan -> col_n=1110, key=0, key_valid=0, key_down=0 immediately, without waiting for a clock edge.
2. Clean press of '5' (row1 low while col1 driven), held 10 frames, then released:
   - exactly one key_valid pulse, with key=5, one cycle after the 3rd matching frame end;
   - key_down falls after 3 empty frames;
   - no further pulses.
3. Bounced '#' (row3/col2 toggling each frame for 2 frames, then stable 5 frames) -> single strobe with key=14; key_down=1.
4. Glitch: '*' present for 2 frames, then released -> no strobe; key stays 0.
5. '1' and 'C' pressed together for 4 frames, then 'C' released with '1' still held -> no strobe during MULTI; strobe key=1 after 3 single frames.
6. Combined hold and reset cases:
   - 'D' accepted (key=13) while held, then '7' added and held -> no second strobe; key stays 13.
   - Assert rst during DEBOUNCE of '9' -> no strobe, all outputs at reset values.
